// File: rtl/div_acc_seq_pkg.sv
// Shared types and constants for the divide-accelerator sequencer:
// FSM state encoding, injected instruction encodings and phase lengths.
package div_acc_seq_pkg;

  typedef enum logic [1:0] {
    S_DIV_IDLE,
    S_DIV_CALC,
    S_DIV_INJ
  } t_div_state;

  localparam logic [15:0] INST_D_EQ_A     = 16'hEC10;
  localparam logic [15:0] INST_M_EQ_D     = 16'hE308;
  localparam logic [15:0] INST_JMP_UNCOND = 16'hEA87;

  localparam int DIV_CALC_CYCLES = 16;
  localparam int DIV_INJ_CYCLES  = 5;

  // A-type instruction: MSB clear, 15-bit immediate.
  function automatic logic [15:0] a_inst(input logic [15:0] v);
    return v & 16'h7FFF;
  endfunction

endpackage

// File: rtl/div_acc_seq_div_core.sv
// Iterative restoring divider, one quotient bit per step, MSB first.
// The quotient shifts into the dividend register as dividend bits shift out.
module div_core #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quot,
  output logic [DIV_W-1:0] rem
);

  logic [DIV_W-1:0] r_dvd;
  logic [DIV_W-1:0] r_dsr;
  logic [DIV_W-1:0] r_rem;
  logic [DIV_W:0]   w_r;
  logic [DIV_W:0]   w_trial;

  assign w_r     = {r_rem, r_dvd[DIV_W-1]};
  assign w_trial = w_r - {1'b0, r_dsr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd <= '0;
      r_dsr <= '0;
      r_rem <= '0;
    end else if (load) begin
      r_dvd <= dividend;
      r_dsr <= divisor;
      r_rem <= '0;
    end else if (step) begin
      // A negative trial leaves r below the divisor, so its top bit is zero.
      if (!w_trial[DIV_W]) begin
        r_rem <= w_trial[DIV_W-1:0];
        r_dvd <= {r_dvd[DIV_W-2:0], 1'b1};
      end else begin
        r_rem <= w_r[DIV_W-1:0];
        r_dvd <= {r_dvd[DIV_W-2:0], 1'b0};
      end
    end
  end

  assign quot = r_dvd;
  assign rem  = r_rem;

endmodule

// File: rtl/div_acc_seq.sv
// Divide-accelerator sequencer: runs a 16-cycle restoring divide, then injects
// five instruction pairs that store Q and R and jump to the loop exit.
module div_acc_seq
  import div_acc_seq_pkg::*;
#(
  parameter logic [14:0] QUOT_ADDR = 15'd1,
  parameter logic [14:0] REM_ADDR  = 15'd2,
  parameter int          DIV_W     = 16
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  StartDiv,
  input  logic [DIV_W-1:0]      Dividend,
  input  logic [DIV_W-1:0]      Divisor,
  input  logic [14:0]           ExitPc,
  input  logic                  Abort,
  output logic                  SelAccInst,
  output logic [1:0][15:0]      InstFromAcc,
  output logic                  StallFetch,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Reject
);

  t_div_state         r_state;
  t_div_state         w_next;
  logic [3:0]         r_cnt;
  logic [2:0]         r_k;
  logic [14:0]        r_exit_pc;
  logic               r_reject;
  logic               w_accept;
  logic               w_reject;
  logic               w_sel;
  logic               w_done;
  logic               w_ops_ok;
  logic [1:0][15:0]   w_inst;
  logic [DIV_W-1:0]   w_quot;
  logic [DIV_W-1:0]   w_rem;

  assign w_ops_ok = (Divisor != '0) && !Divisor[DIV_W-1] && !Dividend[DIV_W-1];

  div_core #(.DIV_W(DIV_W)) u_div_core (
    .clk      (Clk),
    .rst_n    (ResetN),
    .load     (w_accept),
    .step     (r_state == S_DIV_CALC),
    .dividend (Dividend),
    .divisor  (Divisor),
    .quot     (w_quot),
    .rem      (w_rem)
  );

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= S_DIV_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    w_sel    = 1'b0;
    w_done   = 1'b0;
    w_inst   = '0;
    unique case (r_state)
      S_DIV_IDLE: begin
        if (StartDiv) begin
          if (w_ops_ok) begin
            w_accept = 1'b1;
            w_next   = S_DIV_CALC;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_DIV_CALC: begin
        if (r_cnt == 4'd0) w_next = S_DIV_INJ;
      end
      S_DIV_INJ: begin
        w_sel = 1'b1;
        case (r_k)
          3'd0:    w_inst = {INST_D_EQ_A,     a_inst(w_quot)};
          3'd1:    w_inst = {INST_M_EQ_D,     a_inst({1'b0, QUOT_ADDR})};
          3'd2:    w_inst = {INST_D_EQ_A,     a_inst(w_rem)};
          3'd3:    w_inst = {INST_M_EQ_D,     a_inst({1'b0, REM_ADDR})};
          default: w_inst = {INST_JMP_UNCOND, a_inst({1'b0, r_exit_pc})};
        endcase
        if (r_k == 3'(DIV_INJ_CYCLES - 1)) begin
          w_done = 1'b1;
          w_next = S_DIV_IDLE;
        end
      end
      default: w_next = S_DIV_IDLE;
    endcase
    // A flush overrides everything, including a same-cycle start.
    if (Abort) begin
      w_next   = S_DIV_IDLE;
      w_accept = 1'b0;
      w_reject = 1'b0;
      w_done   = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_cnt     <= '0;
      r_k       <= '0;
      r_exit_pc <= '0;
      r_reject  <= 1'b0;
    end else begin
      r_reject <= w_reject;
      if (w_accept) begin
        r_cnt     <= 4'(DIV_CALC_CYCLES - 1);
        r_k       <= '0;
        r_exit_pc <= ExitPc;
      end else if (r_state == S_DIV_CALC) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (r_state == S_DIV_INJ) begin
        r_k <= r_k + 3'd1;
      end
    end
  end

  assign SelAccInst  = w_sel;
  assign InstFromAcc = w_inst;
  assign Busy        = (r_state != S_DIV_IDLE);
  assign StallFetch  = Busy;
  assign Done        = w_done;
  assign Reject      = r_reject;

endmodule

// File: tb/tb_div_acc_seq.sv
// Bench for div_acc_seq: cycle-schedule reference model checked every cycle,
// directed operand cases with literal expectations, then randomized operations.
module tb_div_acc_seq;

  logic              Clk = 1'b0;
  logic              ResetN = 1'b0;
  logic              StartDiv = 1'b0;
  logic              Abort = 1'b0;
  logic [15:0]       Dividend = '0;
  logic [15:0]       Divisor = '0;
  logic [14:0]       ExitPc = '0;
  logic              SelAccInst;
  logic [1:0][15:0]  InstFromAcc;
  logic              StallFetch;
  logic              Busy;
  logic              Done;
  logic              Reject;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  div_acc_seq dut (
    .Clk        (Clk),
    .ResetN     (ResetN),
    .StartDiv   (StartDiv),
    .Dividend   (Dividend),
    .Divisor    (Divisor),
    .ExitPc     (ExitPc),
    .Abort      (Abort),
    .SelAccInst (SelAccInst),
    .InstFromAcc(InstFromAcc),
    .StallFetch (StallFetch),
    .Busy       (Busy),
    .Done       (Done),
    .Reject     (Reject)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: m_c counts cycles since the accepted start (1..21).
  logic        m_act = 1'b0;
  int          m_c = 0;
  logic        m_rej = 1'b0;
  logic [15:0] m_q = '0;
  logic [15:0] m_r = '0;
  logic [14:0] m_pc = '0;

  always @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      m_act <= 1'b0;
      m_c   <= 0;
      m_rej <= 1'b0;
    end else begin
      m_rej <= 1'b0;
      if (m_act) begin
        if (Abort || m_c == 21) m_act <= 1'b0;
        else m_c <= m_c + 1;
      end else if (StartDiv && !Abort) begin
        if (Divisor != 0 && Divisor < 16'h8000 && Dividend < 16'h8000) begin
          m_act <= 1'b1;
          m_c   <= 1;
          m_q   <= Dividend / Divisor;
          m_r   <= Dividend % Divisor;
          m_pc  <= ExitPc;
        end else begin
          m_rej <= 1'b1;
        end
      end
    end
  end

  function automatic logic [31:0] m_pair(input int k);
    case (k)
      0:       return {16'hEC10, 1'b0, m_q[14:0]};
      1:       return {16'hE308, 16'h0001};
      2:       return {16'hEC10, 1'b0, m_r[14:0]};
      3:       return {16'hE308, 16'h0002};
      default: return {16'hEA87, 1'b0, m_pc};
    endcase
  endfunction

  logic exp_sel;
  always @(negedge Clk) begin
    exp_sel = m_act && (m_c >= 17);
    chk("busy",   32'(Busy),        32'(m_act));
    chk("stall",  32'(StallFetch),  32'(m_act));
    chk("sel",    32'(SelAccInst),  32'(exp_sel));
    chk("inst",   32'(InstFromAcc), exp_sel ? m_pair(m_c - 17) : 32'h0);
    chk("done",   32'(Done),        32'(m_act && m_c == 21 && !Abort));
    chk("reject", 32'(Reject),      32'(m_rej));
  end

  logic [31:0] cap[$];
  int stall_cnt, done_at, rej_at;

  function automatic logic [31:0] capk(input int k);
    return (cap.size() > k) ? cap[k] : 32'hDEADBEEF;
  endfunction

  task automatic do_op(input logic [15:0] dvd, input logic [15:0] dsr, input logic [14:0] pc,
                       input int abort_at, input int stray_at);
    cap.delete();
    stall_cnt = 0;
    done_at   = 0;
    rej_at    = 0;
    @(posedge Clk); #1;
    StartDiv = 1'b1; Dividend = dvd; Divisor = dsr; ExitPc = pc;
    @(posedge Clk); #1;
    StartDiv = 1'b0;
    Dividend = 16'($urandom);
    Divisor  = 16'($urandom);
    ExitPc   = 15'($urandom);
    for (int i = 1; i <= 24; i++) begin
      Abort    = (i == abort_at);
      StartDiv = (i == stray_at);
      if (i == stray_at) begin
        Dividend = 16'd7;
        Divisor  = 16'd3;
      end
      @(negedge Clk);
      if (StallFetch) stall_cnt++;
      if (SelAccInst) cap.push_back(32'(InstFromAcc));
      if (Done) done_at = i;
      if (Reject) rej_at = i;
      @(posedge Clk); #1;
    end
    Abort    = 1'b0;
    StartDiv = 1'b0;
  endtask

  initial begin
    int sel;
    logic [15:0] dvd, dsr;
    int ab, st;

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_sel",  32'(SelAccInst), 0);
    chk("rst_inst", 32'(InstFromAcc), 0);
    ResetN = 1'b1;

    do_op(16'd20000, 16'd10, 15'h1234, 0, 0);
    chk("mdl_q_20000", 32'(m_q), 32'd2000);
    chk("mdl_r_20000", 32'(m_r), 32'd0);
    chk("n_pairs", cap.size(), 5);
    chk("pair0", capk(0), {16'hEC10, 16'h07D0});
    chk("pair1", capk(1), {16'hE308, 16'h0001});
    chk("pair2", capk(2), {16'hEC10, 16'h0000});
    chk("pair3", capk(3), {16'hE308, 16'h0002});
    chk("pair4", capk(4), {16'hEA87, 16'h1234});
    chk("done_at", done_at, 21);
    chk("rej_at", rej_at, 0);

    do_op(16'd100, 16'd7, 15'h0040, 0, 0);
    chk("q_100_7", capk(0), {16'hEC10, 16'h000E});
    chk("r_100_7", capk(2), {16'hEC10, 16'h0002});
    chk("stall_100_7", stall_cnt, 21);

    do_op(16'd5, 16'd9, 15'h0010, 0, 0);
    chk("q_5_9", capk(0), {16'hEC10, 16'h0000});
    chk("r_5_9", capk(2), {16'hEC10, 16'h0005});

    do_op(16'd32767, 16'd1, 15'h7FFF, 0, 0);
    chk("q_max", capk(0), {16'hEC10, 16'h7FFF});
    chk("r_max", capk(2), {16'hEC10, 16'h0000});
    chk("pc_max", capk(4), {16'hEA87, 16'h7FFF});

    do_op(16'd50, 16'd0, 15'h0001, 0, 0);
    chk("rej_div0", rej_at, 1);
    chk("rej_div0_stall", stall_cnt, 0);
    chk("rej_div0_pairs", cap.size(), 0);
    do_op(16'd50, 16'h8000, 15'h0001, 0, 0);
    chk("rej_neg", rej_at, 1);
    chk("rej_neg_stall", stall_cnt, 0);
    chk("rej_neg_pairs", cap.size(), 0);

    do_op(16'd1000, 16'd3, 15'h0100, 8, 0);
    chk("abort8_stall", stall_cnt, 8);
    chk("abort8_done", done_at, 0);
    chk("abort8_pairs", cap.size(), 0);
    do_op(16'd1000, 16'd3, 15'h0100, 18, 0);
    chk("abort18_stall", stall_cnt, 18);
    chk("abort18_done", done_at, 0);
    chk("abort18_pairs", cap.size(), 2);

    do_op(16'd999, 16'd10, 15'h0200, 0, 5);
    chk("stray_stall", stall_cnt, 21);
    chk("stray_q", capk(0), {16'hEC10, 16'd99});
    chk("stray_r", capk(2), {16'hEC10, 16'd9});

    // Asynchronous reset in the middle of injection.
    @(posedge Clk); #1;
    StartDiv = 1'b1; Dividend = 16'd100; Divisor = 16'd7;
    @(posedge Clk); #1;
    StartDiv = 1'b0;
    repeat (18) @(posedge Clk);
    #1;
    chk("pre_rst_sel", 32'(SelAccInst), 1);
    #2 ResetN = 1'b0;
    #1;
    chk("arst_busy",  32'(Busy), 0);
    chk("arst_stall", 32'(StallFetch), 0);
    chk("arst_sel",   32'(SelAccInst), 0);
    chk("arst_inst",  32'(InstFromAcc), 0);
    chk("arst_done",  32'(Done), 0);
    @(posedge Clk); #1;
    ResetN = 1'b1;

    for (int n = 0; n < 40; n++) begin
      dvd = 16'($urandom_range(0, 32767));
      sel = $urandom_range(0, 9);
      if (sel == 0)      dsr = 16'd0;
      else if (sel == 1) dsr = 16'h8000 | 16'($urandom);
      else if (sel == 2) begin dsr = 16'($urandom_range(1, 100)); dvd = dvd | 16'h8000; end
      else if (sel < 6)  dsr = 16'($urandom_range(1, 300));
      else               dsr = 16'($urandom_range(1, 32767));
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 22) : 0;
      st = (ab == 0 && $urandom_range(0, 2) == 0) ? $urandom_range(2, 20) : 0;
      do_op(dvd, dsr, 15'($urandom), ab, st);
      repeat ($urandom_range(0, 2)) @(posedge Clk);
    end

    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
